// File: rtl/imem_loader.sv
// imem_loader: streams host words into instruction memory at BASE_ADDR+4*n, holding the core in reset until the load ends.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum word verified before release.
module imem_loader #(
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       load_valid,
  input  logic [31:0]                load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       core_reset,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     word_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR, S_CHECK} state_t;
  logic [31:0] sum;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_t;
`endif

  state_t            state;
  logic              hs;
  logic              full;
  logic [ADDR_W-1:0] word_addr;

  assign hs        = load_valid & load_ready;
  assign full      = (word_count == CNT_W'(DEPTH));
  // Byte address of the next word; wraps modulo 2^ADDR_W.
  assign word_addr = BASE_ADDR + (ADDR_W'(word_count) << 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      load_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LOAD;
            load_ready <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (hs) begin
            if (full) begin
              // One word too many: drop it and abort.
              state      <= S_ERROR;
              error      <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= word_addr;
              mem_wdata  <= load_data;
              word_count <= word_count + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum        <= sum + load_data;
              if (load_last) begin
                state <= S_CHECK;
              end
`else
              if (load_last) begin
                state      <= S_DRAIN;
                load_ready <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (hs) begin
            load_ready <= 1'b0;
            if (load_data == sum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DRAIN: begin
          // Final write lands this cycle; release the core only afterwards.
          state      <= S_DONE;
          done       <= 1'b1;
          core_reset <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          load_ready <= 1'b0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with DEPTH=4, BASE_ADDR=0.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [2:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  imem_loader #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(core_reset), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(load_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    chk("idle_ready", 32'(load_ready), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum: 1+2+3 = 6.
    for (int pass = 0; pass < 2; pass++) begin
      log_addr.delete();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        load_valid = 1'b1; load_data = 32'(i + 1); load_last = (i == 2);
        tick();
        chk("cs_write_addr", mem_addr, 32'(4 * i));
      end
      chk("cs_check_ready", 32'(load_ready), 32'd1);
      load_data = (pass == 0) ? 32'd6 : 32'd7; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      chk("cs_no_write", 32'(mem_we), 32'd0);
      chk("cs_done", 32'(done), (pass == 0) ? 32'd1 : 32'd0);
      chk("cs_error", 32'(error), (pass == 0) ? 32'd0 : 32'd1);
      chk("cs_core_reset", 32'(core_reset), (pass == 0) ? 32'd0 : 32'd1);
      tick();
      chk("cs_log_size", 32'(log_addr.size()), 32'd3);
    end
`else
    // Three back-to-back words, last on the third.
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 32'h00500093; tick();
    chk_write("t1_w0", 32'h0, 32'h00500093);
    chk("t1_count1", 32'(word_count), 32'd1);
    load_data = 32'h00100113; tick();
    chk_write("t1_w1", 32'h4, 32'h00100113);
    load_data = 32'h002081B3; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk_write("t1_w2", 32'h8, 32'h002081B3);
    chk("t1_drain_ready", 32'(load_ready), 32'd0);
    chk("t1_drain_done", 32'(done), 32'd0);
    chk("t1_drain_core_reset", 32'(core_reset), 32'd1);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_core_reset", 32'(core_reset), 32'd0);
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_we_off", 32'(mem_we), 32'd0);
    chk("t1_addr_hold", mem_addr, 32'h8);
    chk("t1_data_hold", mem_wdata, 32'h002081B3);

    // Stalled host: valid every other cycle.
    log_addr.delete(); log_data.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_done_cleared", 32'(done), 32'd0);
    chk("t2_core_reset", 32'(core_reset), 32'd1);
    chk("t2_count_cleared", 32'(word_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 32'hA0 + 32'(i); load_last = (i == 3);
      tick();
      chk_write("t2_w", 32'(4 * i), 32'hA0 + 32'(i));
      load_valid = 1'b0; load_last = 1'b0;
      tick();
      chk("t2_gap_we", 32'(mem_we), 32'd0);
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_log_size", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) chk("t2_log_addr", log_addr[i], 32'(4 * i));
    end

    // Overflow: five words, no last.
    log_addr.delete(); log_data.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = 32'hB0 + 32'(i);
      tick();
      if (i < 4) chk_write("t3_w", 32'(4 * i), 32'hB0 + 32'(i));
    end
    load_valid = 1'b0;
    chk("t3_no_write", 32'(mem_we), 32'd0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_core_reset", 32'(core_reset), 32'd1);
    chk("t3_ready", 32'(load_ready), 32'd0);
    chk("t3_count", 32'(word_count), 32'd4);
    tick();
    chk("t3_error_hold", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_log_size", 32'(log_addr.size()), 32'd4);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_error_cleared", 32'(error), 32'd0);
    chk("t3_count_cleared", 32'(word_count), 32'd0);
    chk("t3_reload_ready", 32'(load_ready), 32'd1);

    // Exactly DEPTH words, last on the fourth.
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 32'hC0 + 32'(i); load_last = (i == 3);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk_write("t4_w3", 32'hC, 32'hC3);
    chk("t4_count", 32'(word_count), 32'd4);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_error", 32'(error), 32'd0);
    chk("t4_core_reset", 32'(core_reset), 32'd0);
    load_valid = 1'b1; load_data = 32'hDEAD; tick(); load_valid = 1'b0;
    chk("t4_ignored_valid_we", 32'(mem_we), 32'd0);
    chk("t4_ignored_valid_done", 32'(done), 32'd1);

    // Reset after 2 of 4 words; start during LOAD is ignored.
    start = 1'b1; tick(); start = 1'b0;
    load_valid = 1'b1; load_data = 32'hD0; tick();
    load_data = 32'hD1; start = 1'b1; tick(); start = 1'b0;
    chk_write("t5_w1", 32'h4, 32'hD1);
    chk("t5_count", 32'(word_count), 32'd2);
    load_data = 32'hD2;
    reset = 1'b1;
    #1;
    chk_reset_vals("t5_async");
    tick();
    reset = 1'b0; load_valid = 1'b0;
    tick();
    chk("t5_idle_ready", 32'(load_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    load_valid = 1'b1; load_data = 32'hE0; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk_write("t5_rewrite", 32'h0, 32'hE0);
    tick();
    chk("t5_done", 32'(done), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
